// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request/result handshake bundle for alu_pipe
interface alu_pipe_if #(parameter int NBITS = 32);
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] a;
  logic [NBITS-1:0] b;
  logic [5:0]       ctrl;
  logic [1:0]       shift;
  logic             mul;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS-1:0] c;
  logic             n;
  logic             z;
  logic             co;
  logic             ov;
  modport master (
    output in_valid, a, b, ctrl, shift, mul, out_ready,
    input  in_ready, out_valid, c, n, z, co, ov
  );
  modport slave (
    input  in_valid, a, b, ctrl, shift, mul, out_ready,
    output in_ready, out_valid, c, n, z, co, ov
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: single-cycle gated ALU plus iterative shift-add multiply with a post shifter
module alu_pipe #(
  parameter int NBITS  = 32,
  parameter bit MUL_EN = 1
) (
  input logic       clk,
  input logic       reset,
  alu_pipe_if.slave bus
);
  localparam int CW = $clog2(NBITS);
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
  state_t           state_q;
  logic             vld_q, n_q, z_q, co_q, ovf_q;
  logic [NBITS-1:0] c_q, ma_q, mb_q, acc_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       sh_q;
  logic [NBITS-1:0] ap, bp, alu, c_d, prod, m_d;
  logic [NBITS:0]   sum;
  logic             add, co_d, ovf_d, accept, do_mul;
  function automatic logic [NBITS-1:0] shf(input logic [NBITS-1:0] x, input logic [1:0] s);
    return s == 2'd1 ? x << 8 : s == 2'd2 ? {x[NBITS-1], x[NBITS-1:1]} : s == 2'd3 ? x >> 1 : x;
  endfunction
  assign bus.in_ready  = state_q == IDLE && (!vld_q || bus.out_ready) && !reset;
  assign bus.out_valid = vld_q;
  assign bus.c         = c_q;
  assign bus.n         = n_q;
  assign bus.z         = z_q;
  assign bus.co        = co_q;
  assign bus.ov        = ovf_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign do_mul        = MUL_EN && bus.mul;
  // ALU result for the incoming request, and the final multiply step seen through the shifter
  always_comb begin
    ap    = (bus.ctrl[3] ? bus.a : '0) ^ {NBITS{bus.ctrl[1]}};
    bp    = bus.ctrl[2] ? bus.b : '0;
    sum   = {1'b0, ap} + {1'b0, bp} + {{NBITS{1'b0}}, bus.ctrl[0]};
    alu   = bus.ctrl[5:4] == 2'b00 ? ap & bp :
            bus.ctrl[5:4] == 2'b01 ? ap | bp :
            bus.ctrl[5:4] == 2'b10 ? ~bp : sum[NBITS-1:0];
    c_d   = shf(alu, bus.shift);
    add   = bus.ctrl[5:4] == 2'b11;
    co_d  = add & sum[NBITS];
    ovf_d = add & (ap[NBITS-1] == bp[NBITS-1]) & (sum[NBITS-1] != ap[NBITS-1]);
    prod  = acc_q + (mb_q[0] ? ma_q : '0);
    m_d   = shf(prod, sh_q);
  end
  // Control FSM with registered result and flags; a multiply consumes one bit of b per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      c_q     <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && !do_mul) begin
            c_q   <= c_d;
            n_q   <= c_d[NBITS-1];
            z_q   <= c_d == '0;
            co_q  <= co_d;
            ovf_q <= ovf_d;
            vld_q <= 1'b1;
          end else if (accept) begin
            ma_q    <= bus.a;
            mb_q    <= bus.b;
            acc_q   <= '0;
            cnt_q   <= '0;
            sh_q    <= bus.shift;
            vld_q   <= 1'b0;
            state_q <= MUL;
          end else if (vld_q && bus.out_ready) begin
            vld_q <= 1'b0;
          end
        end
        MUL: begin
          acc_q <= prod;
          ma_q  <= ma_q << 1;
          mb_q  <= mb_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(NBITS - 1)) begin
            c_q     <= m_d;
            n_q     <= m_d[NBITS-1];
            z_q     <= m_d == '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b1;
            state_q <= bus.out_ready ? IDLE : HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            vld_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed corner cases plus randomized traffic against a scoreboard model
`timescale 1ns/1ps
module tb_alu_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errs = 0;
  int checks = 0;
  logic [35:0] q[$];
  alu_pipe_if #(.NBITS(32)) bus ();
  alu_pipe #(.NBITS(32), .MUL_EN(1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [35:0] res();
    return {bus.c, bus.n, bus.z, bus.co, bus.ov};
  endfunction
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [5:0] ctl, input logic [1:0] sh, input logic m);
    longint unsigned mk = 64'hFFFF_FFFF;
    longint unsigned ap, bp, r;
    longint s;
    logic co = 1'b0;
    logic ov = 1'b0;
    logic [31:0] t;
    if (m) begin
      ap = a;
      bp = b;
      r = (ap * bp) & mk;
    end else begin
      ap = ctl[3] ? a : 0;
      if (ctl[1]) ap = ~ap & mk;
      bp = ctl[2] ? b : 0;
      case (ctl[5:4])
        2'd0: r = ap & bp;
        2'd1: r = ap | bp;
        2'd2: r = ~bp & mk;
        default: begin
          r = ap + bp + ctl[0];
          co = r[32];
          r = r & mk;
          s = longint'($signed(ap[31:0])) + longint'($signed(bp[31:0])) + longint'(ctl[0]);
          ov = s > 64'sd2147483647 || s < -64'sd2147483648;
        end
      endcase
    end
    t = r[31:0];
    case (sh)
      2'd1: t = t << 8;
      2'd2: t = $signed(t) >>> 1;
      2'd3: t = t >> 1;
      default: ;
    endcase
    return {t, t[31], t == 32'd0, co, ov};
  endfunction
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [5:0] cv,
                      input logic [1:0] sv, input logic mv);
    bit ok = 0;
    bus.a = av;
    bus.b = bv;
    bus.ctrl = cv;
    bus.shift = sv;
    bus.mul = mv;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      ok = bus.in_ready;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask
  task automatic sb_cycle();
    logic [35:0] e;
    #1;
    if (bus.out_valid && !bus.out_ready) check("stall_in_ready", bus.in_ready, 0);
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) check("sb_valid_without_request", bus.out_valid, 0);
      else begin
        e = q.pop_front();
        check("sb_result", res(), e);
      end
    end
    if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.ctrl, bus.shift, bus.mul));
    @(negedge clk);
  endtask
  initial begin
    logic [31:0] pick[4];
    int bad;
    pick[0] = 32'h0; pick[1] = 32'hFFFF_FFFF; pick[2] = 32'h7FFF_FFFF; pick[3] = 32'h8000_0000;
    bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.ctrl = 0; bus.shift = 0; bus.mul = 0; bus.out_ready = 1;
    repeat (2) @(negedge clk);
    check("rst_res", res(), 36'h0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    reset = 1'b0;
    #1 check("post_rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    send(32'hFFFF_FFFF, 32'h1, 6'h3C, 2'd0, 1'b0);
    check("add_wrap_valid", bus.out_valid, 1);
    check("add_wrap", res(), {32'h0, 1'b0, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    check("valid_drop", bus.out_valid, 0);
    send(32'h7FFF_FFFF, 32'h1, 6'h3C, 2'd0, 1'b0);
    check("add_ovf", res(), {32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1});
    send(32'h5, 32'h3, 6'h3F, 2'd2, 1'b0);
    check("sub_sra", res(), {32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0});
    send(32'h5, 32'h3, 6'h3F, 2'd3, 1'b0);
    check("sub_srl", res(), {32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0});
    send(32'h1234_5678, 32'h0, 6'h18, 2'd1, 1'b0);
    check("pass_sll8", res(), {32'h3456_7800, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    send(32'h0001_0003, 32'h5, 6'h00, 2'd0, 1'b1);
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      if (bus.in_ready || bus.out_valid) bad++;
      @(negedge clk);
    end
    check("mul_busy_cycles", bad, 0);
    check("mul_valid_at_33", bus.out_valid, 1);
    check("mul_res", res(), {32'h0005_000F, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(32'h1234, 32'h0, 6'h18, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("hold_c", bus.c, 32'h1234);
      check("hold_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    bus.b = 32'hBEEF; bus.ctrl = 6'h14; bus.shift = 2'd0; bus.mul = 1'b0; bus.in_valid = 1'b1;
    #1 check("b2b_in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b_valid", bus.out_valid, 1);
    check("b2b_res", res(), {32'h0000_BEEF, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    send(32'hDEAD_BEEF, 32'hFFFF_FFFF, 6'h00, 2'd0, 1'b1);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1 check("abort_res", res(), 36'h0);
    check("abort_valid", bus.out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("abort_in_ready", bus.in_ready, 1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) bad++;
      @(negedge clk);
    end
    check("abort_no_result", bad, 0);
    send(32'h0, 32'h0, 6'h31, 2'd0, 1'b0);
    check("after_abort_one", res(), {32'h1, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = $urandom_range(3) != 0;
      bus.a = $urandom_range(3) == 0 ? pick[$urandom_range(3)] : $urandom;
      bus.b = $urandom_range(3) == 0 ? pick[$urandom_range(3)] : $urandom;
      bus.ctrl = 6'($urandom);
      bus.shift = 2'($urandom);
      bus.mul = $urandom_range(9) == 0;
      bus.out_ready = $urandom_range(3) != 0;
      sb_cycle();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60; i++) sb_cycle();
    check("sb_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter NBITS, default 32, datapath width, legal range 8..64.
REQ-002 The block SHALL have parameter MUL_EN, default 1; when 1, the iterative multiply is present, and when 0, mul is ignored and the op runs as an ALU op.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, width 1: request valid.
REQ-006 The block SHALL have port in_ready, output, width 1: request accepted this cycle when in_valid is also 1.
REQ-007 The block SHALL have ports a and b, inputs, width NBITS each: operands.
REQ-008 The block SHALL have port ctrl, input, width 6, with fields f[5:4], ena[3], enb[2], inva[1], inc[0].
REQ-009 The block SHALL have port shift, input, width 2: 00 none, 01 SLL8, 10 SRA1, 11 SRL1.
REQ-010 The block SHALL have port mul, input, width 1: 1 selects the unsigned multiply of a*b; ctrl is ignored when mul is 1.
REQ-011 The block SHALL have port out_valid, input direction reversed: out_valid is an output, width 1, meaning result valid.
REQ-012 The block SHALL have port out_ready, input, width 1: consumer accepts the result.
REQ-013 The block SHALL have port c, output, width NBITS: result.
REQ-014 The block SHALL have ports n, z, co, ov, outputs, width 1 each: negative, zero, carry-out and signed-overflow flags.

Function
REQ-015 Operand gating SHALL be A' = ena ? a : 0, then inverted if inva, and B' = enb ? b : 0.
REQ-016 The f field SHALL select 00 A' AND B', 01 A' OR B', 10 NOT B', 11 A' + B' + inc, all modulo 2^NBITS.
REQ-017 Required encodings SHALL hold: 0x18=A, 0x14=B, 0x1A=~A, 0x2C=~B, 0x3C=A+B, 0x3D=A+B+1, 0x39=A+1, 0x35=B+1, 0x3F=B-A, 0x36=B-1, 0x3B=-A, 0x0C=AND, 0x1C=OR, 0x10=0, 0x31=1, 0x32=-1.
REQ-018 Each of the 64 ctrl codes SHALL produce a defined result per REQ-015/REQ-016, with no X output.
REQ-019 The shifter SHALL act on the ALU or multiply result: SLL8 shifts left 8 with zero fill, SRA1 shifts right 1 replicating the MSB, SRL1 shifts right 1 with zero fill.
REQ-020 Flags SHALL be n = c[NBITS-1] and z = (c == 0), both taken after the shift.
REQ-021 co SHALL be the adder carry out of bit NBITS-1 when f=11, and 0 otherwise or for mul.
REQ-022 ov SHALL be set when f=11 and A' and B' have equal sign that differs from the sum sign, and 0 otherwise or for mul.
REQ-023 The FSM SHALL have states IDLE, MUL and HOLD.
REQ-024 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready) && !reset.
REQ-025 For an accepted ALU op (mul=0), c, n, z, co and ov SHALL register on the accepting edge, with out_valid=1 from the next cycle (latency 1).
REQ-026 Back-to-back ALU ops SHALL sustain throughput of 1 per cycle when out_ready=1.
REQ-027 For an accepted mul, the operands SHALL be latched and the FSM SHALL go to MUL, running a shift-add with one bit of b per cycle for NBITS cycles (low NBITS of the product) and then applying the shift.
REQ-028 The mul result SHALL be valid exactly NBITS+1 cycles after acceptance, with the FSM going to HOLD if out_valid && !out_ready at completion, else to IDLE.
REQ-029 While out_valid=1 and out_ready=0, c and all flags SHALL hold stable and in_ready SHALL be 0.
REQ-030 out_valid SHALL fall after the handshake edge unless a new op is accepted on the same edge.
REQ-031 On a simultaneous out_ready handshake and new ALU acceptance, the new result SHALL replace the old on that edge.
REQ-032 out_valid SHALL stay 0 during MUL, apart from a prior result still being held.
REQ-033 Inputs SHALL be ignored whenever in_ready=0.

Reset
REQ-034 On reset assertion the block SHALL immediately force state=IDLE, out_valid=0, c=0, n=0, z=0, co=0, ov=0 and clear the multiply registers, asynchronously.
REQ-035 Reset asserted mid-multiply SHALL abort the multiply with no result emitted, and in_ready SHALL be 1 on the first cycle after reset deasserts.

Verification (NBITS=32)
REQ-036 A bench SHALL cover: ctrl=0x3C, a=0xFFFFFFFF, b=1, shift=00 -> c=0, z=1, co=1, ov=0, n=0, out_valid 1 cycle later.
REQ-037 A bench SHALL cover: ctrl=0x3C, a=0x7FFFFFFF, b=1 -> c=0x80000000, n=1, ov=1, co=0.
REQ-038 A bench SHALL cover: ctrl=0x3F, a=5, b=3, shift=10 -> c=0xFFFFFFFF (−2 SRA1 = −1), n=1, then shift=11 -> c=0x7FFFFFFF.
REQ-039 A bench SHALL cover: mul=1, a=0x00010003, b=0x00000005 -> c=0x0005000F exactly 33 cycles after acceptance, with in_ready=0 throughout.
REQ-040 A bench SHALL cover: out_ready=0 for 5 cycles with result held -> c stable and in_ready=0, then out_ready=1 with in_valid=1 -> new result on the next edge, with no bubble.
REQ-041 A bench SHALL cover: reset pulse at cycle 10 of a mul -> out_valid stays 0, all outputs 0, and a new ALU op 0x31 returns c=1.
